// File: rtl/cla_pkg.sv
// Shared constants and types for the two-level carry-lookahead adder.
package cla_pkg;

    localparam int CLA_WIDTH = 8;
    localparam int CLA_GROUP = 4;

    typedef logic [CLA_WIDTH-1:0] cla_word_t;

endpackage

// File: rtl/cla_group4.sv
// 4-bit lookahead group: flat sum-of-products internal carries plus group generate/propagate.
module cla_group4 (
    input  logic [3:0] p,
    input  logic [3:0] g,
    input  logic       cin,
    output logic [2:0] c,
    output logic       grp_g,
    output logic       grp_p
);

    // c[0..2] are the carries into bits 1..3 of the group
    assign c[0] = g[0]
                | (p[0] & cin);
    assign c[1] = g[1]
                | (p[1] & g[0])
                | (p[1] & p[0] & cin);
    assign c[2] = g[2]
                | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);

    assign grp_g = g[3]
                 | (p[3] & g[2])
                 | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);
    assign grp_p = &p;

endmodule

// File: rtl/carry_lookahead_adder.sv
// Registered WIDTH-bit adder: 4-bit lookahead groups, a group-level lookahead unit,
// XOR sum stage and a single output register stage.
module carry_lookahead_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH,
    parameter int GROUP = CLA_GROUP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             C0,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int NG = WIDTH / GROUP;

    logic [WIDTH-1:0]   bit_g;
    logic [WIDTH-1:0]   bit_p;
    logic [NG-1:0]      grp_g;
    logic [NG-1:0]      grp_p;
    logic [NG:0]        grp_c;
    logic [GROUP-2:0]   int_c [NG];
    logic [WIDTH-1:0]   carry_vec;
    logic [WIDTH-1:0]   sum_c;

    assign bit_g = X & Y;
    assign bit_p = X ^ Y;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla_group4 u_grp (
            .p     (bit_p[GROUP*k +: GROUP]),
            .g     (bit_g[GROUP*k +: GROUP]),
            .cin   (grp_c[k]),
            .c     (int_c[k]),
            .grp_g (grp_g[k]),
            .grp_p (grp_p[k])
        );
    end

    // Group carry-in k is the OR over j of (generate at j) AND (propagate of every group above j
    // and below k); term j=0 uses C0 as the generate. Each carry sees only C0 and lower groups.
    always_comb begin
        logic term;
        grp_c    = '0;
        grp_c[0] = C0;
        for (int k = 1; k <= NG; k++) begin
            for (int j = 0; j <= k - 1 + 1; j++) begin
                if (j <= k) begin
                    term = (j == 0) ? C0 : grp_g[(j == 0) ? 0 : j-1];
                    for (int m = 0; m < NG; m++) begin
                        if (m >= j && m < k) term = term & grp_p[m];
                    end
                    if (j < k || (j == k && k > 0)) grp_c[k] = grp_c[k] | term;
                end
            end
        end
    end

    always_comb begin
        carry_vec = '0;
        for (int k = 0; k < NG; k++) begin
            carry_vec[GROUP*k]              = grp_c[k];
            carry_vec[GROUP*k+1 +: GROUP-1] = int_c[k];
        end
    end

    assign sum_c = bit_p ^ carry_vec;

    // Output register stage; reset wins over any operand activity
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum       <= '0;
            carry_out <= 1'b0;
        end else begin
            sum       <= sum_c;
            carry_out <= grp_c[NG];
        end
    end

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// Self-checking bench for carry_lookahead_adder: directed cases, accumulator feedback,
// mid-run reset and randomized vectors against a plain-arithmetic reference.
module tb_carry_lookahead_adder;
    import cla_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n;
    cla_word_t X;
    cla_word_t Y;
    logic      C0;
    cla_word_t sum;
    logic      carry_out;

    logic      fb;
    cla_word_t yd;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always_comb Y = fb ? sum : yd;

    carry_lookahead_adder #(.WIDTH(8), .GROUP(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .X         (X),
        .Y         (Y),
        .C0        (C0),
        .sum       (sum),
        .carry_out (carry_out)
    );

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed {co,sum}=%03h expected %03h", tag, obs, exp);
        end
    endtask

    // Apply operands at negedge; result must be visible right after the next rising edge.
    task automatic add_step(input string tag, input logic [7:0] x, input logic [7:0] y,
                            input logic c, input logic [7:0] exp_sum, input logic exp_co);
        @(negedge clk);
        fb = 1'b0; X = x; yd = y; C0 = c;
        @(posedge clk); #1;
        check(tag, {carry_out, sum}, {exp_co, exp_sum});
    endtask

    initial begin
        logic [7:0] acc;
        logic [8:0] nxt;
        logic [8:0] ref9;
        logic [7:0] rx, ry;
        logic       rc;

        fb = 1'b0; X = 8'hA5; yd = 8'h5A; C0 = 1'b1; rst_n = 1'b0;

        // Reset held for two edges with live operands
        repeat (2) @(posedge clk);
        #1 check("reset", {carry_out, sum}, 9'h000);
        @(negedge clk); rst_n = 1'b1;

        add_step("1+2",     8'd1,   8'd2,   1'b0, 8'd3,   1'b0);
        add_step("1+8",     8'd1,   8'd8,   1'b0, 8'd9,   1'b0);
        add_step("1+16",    8'd1,   8'd16,  1'b0, 8'd17,  1'b0);
        add_step("1+1",     8'd1,   8'd1,   1'b0, 8'd2,   1'b0);
        add_step("2+2",     8'd2,   8'd2,   1'b0, 8'd4,   1'b0);
        add_step("4+4",     8'd4,   8'd4,   1'b0, 8'd8,   1'b0);
        add_step("8+8",     8'd8,   8'd8,   1'b0, 8'd16,  1'b0);
        add_step("16+16",   8'd16,  8'd16,  1'b0, 8'd32,  1'b0);
        add_step("32+32",   8'd32,  8'd32,  1'b0, 8'd64,  1'b0);
        add_step("64+64",   8'd64,  8'd64,  1'b0, 8'd128, 1'b0);
        add_step("7+7",     8'd7,   8'd7,   1'b0, 8'd14,  1'b0);
        add_step("15+15",   8'd15,  8'd15,  1'b0, 8'd30,  1'b0);
        add_step("127+128", 8'd127, 8'd128, 1'b0, 8'd255, 1'b0);
        add_step("128+128", 8'd128, 8'd128, 1'b0, 8'd0,   1'b1);
        add_step("255+1",   8'd255, 8'd1,   1'b0, 8'd0,   1'b1);
        add_step("FF+FF+1", 8'hFF,  8'hFF,  1'b1, 8'hFF,  1'b1);
        add_step("FF+0+1",  8'hFF,  8'h00,  1'b1, 8'h00,  1'b1);
        add_step("0+0+1",   8'h00,  8'h00,  1'b1, 8'h01,  1'b0);

        // Accumulator: Y fed back from sum, starting from a fresh reset
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1 check("acc_reset", {carry_out, sum}, 9'h000);
        @(negedge clk); rst_n = 1'b1; fb = 1'b1; X = 8'd1; C0 = 1'b0;
        acc = 8'd0;
        for (int n = 1; n <= 266; n++) begin
            @(posedge clk); #1;
            nxt = {1'b0, acc} + 9'd1;
            acc = nxt[7:0];
            check("acc_step", {carry_out, sum}, nxt);
            if (n == 200) check("acc_200", {carry_out, sum}, {1'b0, 8'd200});
            if (n == 255) check("acc_255", {carry_out, sum}, {1'b0, 8'd255});
            if (n == 256) check("acc_256", {carry_out, sum}, {1'b1, 8'd0});
        end

        // Reset in the middle of counting, then resume from 1
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1 check("mid_reset", {carry_out, sum}, 9'h000);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1 check("resume_1", {carry_out, sum}, 9'h001);
        @(posedge clk); #1 check("resume_2", {carry_out, sum}, 9'h002);

        // Randomized operands against a 9-bit arithmetic reference
        @(negedge clk); fb = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            rx = 8'($urandom_range(0, 255));
            ry = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            X = rx; yd = ry; C0 = rc;
            ref9 = {1'b0, rx} + {1'b0, ry} + {8'd0, rc};
            @(posedge clk); #1;
            check("random", {carry_out, sum}, ref9);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
